// File: rtl/stream_downsizer_pkg.sv
// stream_downsizer_pkg
// Shared definitions for the stream downsizer:
//   state_t : two-state holding FSM (EMPTY = nothing held, FULL = word held).
// The encodings are fixed explicitly so they match the legacy localparam values.
package stream_downsizer_pkg;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage : stream_downsizer_pkg

// File: rtl/stream_downsizer.sv
// stream_downsizer
// Accepts one IN_WIDTH word per valid/grant handshake and replays it as
// RATIO = IN_WIDTH/OUT_WIDTH narrow beats, least-significant slice first.
// The last beat of each word is flagged. A new word is accepted in the same
// cycle that the last beat of the current word is granted, so the output
// runs at one beat per cycle without a bubble between words.
//
// Ports:
//   clk          clock, all state updates on posedge
//   rst_n        asynchronous active-low reset
//   in_data_i    wide input word (from FIFO data output)
//   in_valid_i   input word available
//   in_grant_o   input word accepted when high together with in_valid_i
//   out_data_o   current narrow beat
//   out_valid_o  beat available
//   out_last_o   current beat is the final slice of its word
//   out_grant_i  consumer accepts the beat when high together with out_valid_o
//   flush_i      synchronous clear of any partially sent word (highest priority)
//   busy_o       a word is held (same as out_valid_o)
module stream_downsizer
  import stream_downsizer_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_grant_o,
  output logic [OUT_WIDTH-1:0] out_data_o,
  output logic                 out_valid_o,
  output logic                 out_last_o,
  input  logic                 out_grant_i,
  input  logic                 flush_i,
  output logic                 busy_o
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  // Elaboration-time parameter sanity check.
  if ((OUT_WIDTH < 1) || ((IN_WIDTH % OUT_WIDTH) != 0)) begin : g_bad_param
    $error("stream_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH and OUT_WIDTH >= 1");
  end

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [IN_WIDTH-1:0] hold_q;

  logic full;
  logic cnt_at_last;
  logic load;
  logic beat_taken;

  assign full        = (state_q == FULL);
  assign cnt_at_last = (cnt_q == CNT_W'(RATIO - 1));

  assign out_valid_o = full;
  assign busy_o      = full;
  assign out_last_o  = full && cnt_at_last;

  // Combinational on out_grant_i so the refill lands in the same cycle the
  // last beat leaves.
  assign in_grant_o  = !flush_i && (!full || (out_last_o && out_grant_i));
  assign load        = in_valid_i && in_grant_o;
  assign beat_taken  = full && out_grant_i;

  always_comb begin
    out_data_o = hold_q[32'(cnt_q) * OUT_WIDTH +: OUT_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else if (flush_i) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
    end else if (beat_taken) begin
      if (cnt_at_last) begin
        cnt_q <= '0;
        if (load) begin
          hold_q  <= in_data_i;
          state_q <= FULL;
        end else begin
          state_q <= EMPTY;
        end
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else if (!full && load) begin
      hold_q  <= in_data_i;
      cnt_q   <= '0;
      state_q <= FULL;
    end
  end

endmodule : stream_downsizer

// File: tb/tb_stream_downsizer.sv
// Self-checking bench for stream_downsizer: a 32->8 instance driven by a
// directed cycle table, a mid-word reset sequence and a randomized run
// against a beat-queue reference model; plus a 16->16 (RATIO=1) instance.
module tb_stream_downsizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // 32 -> 8 instance
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_grant;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_grant = 1'b0;
  logic        flush = 1'b0;
  logic        busy;

  // 16 -> 16 instance
  logic [15:0] r1_in_data = '0;
  logic        r1_in_valid = 1'b0;
  logic        r1_in_grant;
  logic [15:0] r1_out_data;
  logic        r1_out_valid;
  logic        r1_out_last;
  logic        r1_out_grant = 1'b0;
  logic        r1_flush = 1'b0;
  logic        r1_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_grant_o(in_grant),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_last_o(out_last),
    .out_grant_i(out_grant), .flush_i(flush), .busy_o(busy)
  );

  stream_downsizer #(.IN_WIDTH(16), .OUT_WIDTH(16)) u_r1 (
    .clk(clk), .rst_n(rst_n),
    .in_data_i(r1_in_data), .in_valid_i(r1_in_valid), .in_grant_o(r1_in_grant),
    .out_data_o(r1_out_data), .out_valid_o(r1_out_valid), .out_last_o(r1_out_last),
    .out_grant_i(r1_out_grant), .flush_i(r1_flush), .busy_o(r1_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] d;
    logic        v;
    logic        g;
    logic        f;
    logic        ev;
    logic [7:0]  ed;
    logic        el;
    logic        eg;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [31:0] d, input logic v, input logic g, input logic f,
                     input logic ev, input logic [7:0] ed, input logic el, input logic eg);
    vec_t e;
    e.d = d; e.v = v; e.g = g; e.f = f; e.ev = ev; e.ed = ed; e.el = el; e.eg = eg;
    tbl.push_back(e);
  endtask

  // Beats still to be emitted for the held word, oldest first.
  logic [7:0] mq[$];

  initial begin
    logic       exp_v, exp_l, exp_g;
    logic [7:0] exp_d;
    logic [31:0] w;

    // ---------------- directed cycle table (one row per cycle) ----------------
    //   data          v  g  f   ev data  last grant
    // single word, continuous grant
    add(32'hDDCCBBAA, 1, 1, 0,  0, 8'h00, 0, 1);
    add(32'h0,        0, 1, 0,  1, 8'hAA, 0, 0);
    add(32'h0,        0, 1, 0,  1, 8'hBB, 0, 0);
    add(32'h0,        0, 1, 0,  1, 8'hCC, 0, 0);
    add(32'h0,        0, 1, 0,  1, 8'hDD, 1, 1);
    // back-to-back words, no bubble
    add(32'h04030201, 1, 1, 0,  0, 8'h00, 0, 1);
    add(32'h08070605, 1, 1, 0,  1, 8'h01, 0, 0);
    add(32'h08070605, 1, 1, 0,  1, 8'h02, 0, 0);
    add(32'h08070605, 1, 1, 0,  1, 8'h03, 0, 0);
    add(32'h08070605, 1, 1, 0,  1, 8'h04, 1, 1);
    add(32'h0,        0, 1, 0,  1, 8'h05, 0, 0);
    add(32'h0,        0, 1, 0,  1, 8'h06, 0, 0);
    add(32'h0,        0, 1, 0,  1, 8'h07, 0, 0);
    add(32'h0,        0, 1, 0,  1, 8'h08, 1, 1);
    // backpressure on beat BB, and on the last beat
    add(32'hDDCCBBAA, 1, 1, 0,  0, 8'h00, 0, 1);
    add(32'h11223344, 1, 1, 0,  1, 8'hAA, 0, 0);
    add(32'h11223344, 1, 0, 0,  1, 8'hBB, 0, 0);
    add(32'h11223344, 1, 0, 0,  1, 8'hBB, 0, 0);
    add(32'h11223344, 1, 0, 0,  1, 8'hBB, 0, 0);
    add(32'h11223344, 1, 1, 0,  1, 8'hBB, 0, 0);
    add(32'h11223344, 1, 1, 0,  1, 8'hCC, 0, 0);
    add(32'h11223344, 1, 0, 0,  1, 8'hDD, 1, 0);
    add(32'h11223344, 1, 1, 0,  1, 8'hDD, 1, 1);
    // flush after first beat of 0x11223344
    add(32'h0,        0, 1, 0,  1, 8'h44, 0, 0);
    add(32'h99999999, 1, 0, 1,  1, 8'h33, 0, 0);
    add(32'hA1B2C3D4, 1, 1, 0,  0, 8'h00, 0, 1);
    add(32'h0,        0, 1, 0,  1, 8'hD4, 0, 0);
    add(32'h0,        0, 1, 0,  1, 8'hC3, 0, 0);
    add(32'h0,        0, 1, 0,  1, 8'hB2, 0, 0);
    add(32'h0,        0, 1, 0,  1, 8'hA1, 1, 1);
    add(32'h0,        0, 1, 0,  0, 8'h00, 0, 1);
    // flush while empty blocks the load
    add(32'h55555555, 1, 1, 1,  0, 8'h00, 0, 0);
    add(32'h0,        0, 1, 0,  0, 8'h00, 0, 1);

    // ---------------- reset values ----------------
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last",  32'(out_last),  32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_grant", 32'(in_grant),  32'd1);
    chk("r1_rst_data",  32'(r1_out_data),  32'd0);
    chk("r1_rst_valid", 32'(r1_out_valid), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < tbl.size(); i++) begin
      in_data = tbl[i].d; in_valid = tbl[i].v; out_grant = tbl[i].g; flush = tbl[i].f;
      #2;
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_busy", i),  32'(busy),      32'(tbl[i].ev));
      chk($sformatf("tbl%0d_last", i),  32'(out_last),  32'(tbl[i].el));
      chk($sformatf("tbl%0d_grant", i), 32'(in_grant),  32'(tbl[i].eg));
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].ed));
      cyc();
    end
    in_valid = 1'b0; flush = 1'b0;

    // ---------------- reset asserted mid-word at beat CC ----------------
    in_data = 32'hDDCCBBAA; in_valid = 1'b1; out_grant = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc(); // beat AA granted
    cyc(); // beat BB granted
    #2;
    chk("mid_beat_cc", 32'(out_data), 32'hCC);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data",  32'(out_data),  32'd0);
    chk("arst_last",  32'(out_last),  32'd0);
    chk("arst_busy",  32'(busy),      32'd0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_idle", 32'(out_valid), 32'd0);
    end

    // ---------------- RATIO = 1 build ----------------
    r1_out_grant = 1'b1;
    r1_in_data = 16'h1234; r1_in_valid = 1'b1;
    #2;
    chk("r1_grant0", 32'(r1_in_grant), 32'd1);
    chk("r1_valid0", 32'(r1_out_valid), 32'd0);
    cyc();
    r1_in_data = 16'h5678;
    #2;
    chk("r1_data1",  32'(r1_out_data),  32'h1234);
    chk("r1_last1",  32'(r1_out_last),  32'd1);
    chk("r1_grant1", 32'(r1_in_grant),  32'd1);
    cyc();
    r1_in_valid = 1'b0; r1_out_grant = 1'b0;
    #2;
    chk("r1_data2",  32'(r1_out_data),  32'h5678);
    chk("r1_last2",  32'(r1_out_last),  32'd1);
    chk("r1_hold_grant", 32'(r1_in_grant), 32'd0);
    cyc();
    r1_out_grant = 1'b1;
    #2;
    chk("r1_held",   32'(r1_out_data),  32'h5678);
    cyc();
    #2;
    chk("r1_empty",  32'(r1_out_valid), 32'd0);
    r1_out_grant = 1'b0;

    // ---------------- randomized run vs beat-queue model ----------------
    mq.delete();
    for (int c = 0; c < 3000; c++) begin
      in_data   = $urandom;
      in_valid  = ($urandom_range(0, 99) < 70);
      out_grant = ($urandom_range(0, 99) < 70);
      flush     = ($urandom_range(0, 99) < 4);
      exp_v = (mq.size() != 0);
      exp_l = (mq.size() == 1);
      exp_g = !flush && ((mq.size() == 0) || ((mq.size() == 1) && out_grant));
      exp_d = exp_v ? mq[0] : 8'h00;
      #2;
      chk("rnd_valid", 32'(out_valid), 32'(exp_v));
      chk("rnd_last",  32'(out_last),  32'(exp_l));
      chk("rnd_grant", 32'(in_grant),  32'(exp_g));
      chk("rnd_busy",  32'(busy),      32'(exp_v));
      if (exp_v) chk("rnd_data", 32'(out_data), 32'(exp_d));
      if (flush) begin
        mq.delete();
      end else begin
        if (exp_v && out_grant) void'(mq.pop_front());
        if (in_valid && exp_g) begin
          w = in_data;
          for (int k = 0; k < 4; k++) mq.push_back(w[8*k +: 8]);
        end
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_stream_downsizer
